// File: rtl/demux_bank.sv
// rtl/demux_bank.sv - registered 1-to-2**EXP demultiplexer bank with one-hot landing strobe.
// Macro DEMUX_BANK_PIPE_EN registers each tree level (latency EXP); default build lands in one edge.
module demux_bank #(
  parameter int EXP = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [EXP-1:0]    sel,
  input  logic              in,
  input  logic              clr,
  output logic [2**EXP-1:0] out,
  output logic [2**EXP-1:0] hit
);

  if (EXP < 1) begin : g_exp_check
    $error("demux_bank: EXP must be > 0");
  end

  logic           flush;
  logic           leaf_vld;
  logic           leaf_dat;
  logic [EXP-1:0] leaf_sel;

  assign flush = reset | clr;

`ifdef DEMUX_BANK_PIPE_EN
  if (EXP > 1) begin : g_pipe
    localparam int NS = EXP - 1;

    logic [NS-1:0]  vld;
    logic [NS-1:0]  dat;
    logic [EXP-1:0] path [NS];

    // Stage s has resolved routing bits sel[EXP-1:EXP-1-s]; the full index rides
    // along so the leaf level can pick its target flop with the remaining sel[0].
    always_ff @(posedge clk) begin
      if (flush) begin
        vld <= '0;
      end else begin
        vld[0] <= wr_en;
        for (int s = 1; s < NS; s++) vld[s] <= vld[s-1];
      end
      dat[0]  <= in;
      path[0] <= sel;
      for (int s = 1; s < NS; s++) begin
        dat[s]  <= dat[s-1];
        path[s] <= path[s-1];
      end
    end

    assign leaf_vld = vld[NS-1];
    assign leaf_dat = dat[NS-1];
    assign leaf_sel = path[NS-1];
  end else begin : g_single
    assign leaf_vld = wr_en;
    assign leaf_dat = in;
    assign leaf_sel = sel;
  end
`else
  assign leaf_vld = wr_en;
  assign leaf_dat = in;
  assign leaf_sel = sel;
`endif

  // Leaf level: only the addressed flop loads; every other bit holds.
  always_ff @(posedge clk) begin
    if (flush) begin
      out <= '0;
      hit <= '0;
    end else begin
      hit <= '0;
      if (leaf_vld) begin
        out[leaf_sel] <= leaf_dat;
        hit[leaf_sel] <= 1'b1;
      end
    end
  end

endmodule
